// File: rtl/wave_gen_pkg.sv
// Shared types for the waveform generator control path: wave codes, command
// opcodes, controller states and the committed configuration record.
package wave_gen_pkg;

    typedef enum logic [2:0] {
        SINE   = 3'd0,
        TRI    = 3'd1,
        SAW    = 3'd2,
        SQUARE = 3'd3,
        ECG    = 3'd4
    } wave_e;

    localparam logic [2:0] WAVE_LAST = 3'd4;

    typedef enum logic [2:0] {
        OP_SET_WAVE   = 3'd0,
        OP_SET_FLAGS  = 3'd1,
        OP_SET_FREQ   = 3'd2,
        OP_AUTO_START = 3'd3,
        OP_AUTO_STOP  = 3'd4
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PEND      = 2'd1,
        ST_AUTO      = 2'd2,
        ST_AUTO_PEND = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic [2:0] wave_sel;
        logic       amp;
        logic       inc_freq;
        logic       noise_in;
        logic       duty_cycle;
    } cfg_t;

    function automatic logic [2:0] next_wave(input logic [2:0] w);
        return (w >= WAVE_LAST) ? 3'(SINE) : w + 3'd1;
    endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Free-running divider producing a one-cycle sample strobe every SAMPLE_DIV
// clocks; the strobe is high while the count sits at its last value.
module sample_strobe_gen
    import wave_gen_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic sample
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] COUNT_LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = (count_reg == COUNT_LAST) ? '0 : count_reg + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign sample = (count_reg == COUNT_LAST);

endmodule

// File: rtl/wave_gen_ctrl.sv
// Command sequencer for the waveform generator: accepts config commands,
// commits them on sample boundaries and optionally sweeps through the waves.
module wave_gen_ctrl
    import wave_gen_pkg::*;
#(
    parameter int SAMPLE_DIV    = 1000,
    parameter int DWELL_SAMPLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_data,
    output logic       cmd_err,
    output logic       sample,
    output logic [2:0] wave_sel,
    output logic       amp,
    output logic       inc_freq,
    output logic       noise_in,
    output logic       duty_cycle,
    output logic       auto_active
);

    localparam int DW = (DWELL_SAMPLES > 1) ? $clog2(DWELL_SAMPLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_SAMPLES - 1);

    localparam logic [1:0] IDLE      = ST_IDLE;
    localparam logic [1:0] PEND      = ST_PEND;
    localparam logic [1:0] AUTO      = ST_AUTO;
    localparam logic [1:0] AUTO_PEND = ST_AUTO_PEND;

    logic [1:0]    state_reg, state_next;
    cfg_t          cfg_reg, cfg_next;
    cfg_t          shadow_reg, shadow_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic          err_reg, err_next;
    logic          live_reg;
    logic          in_auto;
    logic          xfer;
    logic          sweep_step;

    sample_strobe_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .sample(sample)
    );

    // live_reg holds cmd_ready low for the first cycle after reset release
    assign in_auto   = (state_reg == AUTO) || (state_reg == AUTO_PEND);
    assign cmd_ready = live_reg && ((state_reg == IDLE) || (state_reg == AUTO));
    assign xfer      = cmd_valid && cmd_ready;

    always_comb begin
        state_next  = state_reg;
        cfg_next    = cfg_reg;
        shadow_next = shadow_reg;
        dwell_next  = dwell_reg;
        err_next    = 1'b0;
        sweep_step  = 1'b0;

        if (in_auto && sample) begin
            if (dwell_reg == DWELL_LAST) begin
                dwell_next        = '0;
                sweep_step        = 1'b1;
                cfg_next.wave_sel = next_wave(cfg_reg.wave_sel);
            end else begin
                dwell_next = dwell_reg + DW'(1);
            end
        end

        case (state_reg)
            IDLE, AUTO: begin
                if (xfer) begin
                    case (cmd_op)
                        OP_SET_WAVE: begin
                            if (in_auto || (cmd_data > WAVE_LAST)) begin
                                err_next = 1'b1;
                            end else begin
                                shadow_next          = cfg_reg;
                                shadow_next.wave_sel = cmd_data;
                                state_next           = PEND;
                            end
                        end
                        OP_SET_FLAGS: begin
                            shadow_next            = cfg_reg;
                            shadow_next.noise_in   = cmd_data[2];
                            shadow_next.amp        = cmd_data[1];
                            shadow_next.duty_cycle = cmd_data[0];
                            state_next             = in_auto ? AUTO_PEND : PEND;
                        end
                        OP_SET_FREQ: begin
                            shadow_next          = cfg_reg;
                            shadow_next.inc_freq = cmd_data[0];
                            state_next           = in_auto ? AUTO_PEND : PEND;
                        end
                        OP_AUTO_START: begin
                            if (in_auto) begin
                                err_next = 1'b1;
                            end else begin
                                state_next = AUTO;
                                dwell_next = '0;
                            end
                        end
                        OP_AUTO_STOP: begin
                            if (!in_auto) begin
                                err_next = 1'b1;
                            end else begin
                                state_next = IDLE;
                            end
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end
            PEND: begin
                if (sample) begin
                    cfg_next   = shadow_reg;
                    state_next = IDLE;
                end
            end
            AUTO_PEND: begin
                // The sweep owns wave_sel in auto mode; the shadow only carries flags
                if (sample) begin
                    cfg_next          = shadow_reg;
                    cfg_next.wave_sel = sweep_step ? next_wave(cfg_reg.wave_sel)
                                                   : cfg_reg.wave_sel;
                    state_next        = AUTO;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg  <= IDLE;
            cfg_reg    <= '0;
            shadow_reg <= '0;
            dwell_reg  <= '0;
            err_reg    <= 1'b0;
            live_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cfg_reg    <= cfg_next;
            shadow_reg <= shadow_next;
            dwell_reg  <= dwell_next;
            err_reg    <= err_next;
            live_reg   <= 1'b1;
        end
    end

    assign cmd_err     = err_reg;
    assign wave_sel    = cfg_reg.wave_sel;
    assign amp         = cfg_reg.amp;
    assign inc_freq    = cfg_reg.inc_freq;
    assign noise_in    = cfg_reg.noise_in;
    assign duty_cycle  = cfg_reg.duty_cycle;
    assign auto_active = in_auto;

endmodule

// File: tb/tb_wave_gen_ctrl.sv
// Directed plus randomized stimulus for wave_gen_ctrl, checked every cycle
// against a cycle-count based behavioural model of the controller.
module tb_wave_gen_ctrl;

    localparam int DIV   = 4;
    localparam int DWELL = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_data;
    logic       cmd_err;
    logic       sample;
    logic [2:0] wave_sel;
    logic       amp;
    logic       inc_freq;
    logic       noise_in;
    logic       duty_cycle;
    logic       auto_active;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit m_live, m_auto, m_pend, m_err, last_xfer;
    int m_cyc, m_dwell, m_wave, p_wave;
    bit m_amp, m_inc, m_noise, m_duty;
    bit p_amp, p_inc, p_noise, p_duty;

    wave_gen_ctrl #(
        .SAMPLE_DIV   (DIV),
        .DWELL_SAMPLES(DWELL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_err    (cmd_err),
        .sample     (sample),
        .wave_sel   (wave_sel),
        .amp        (amp),
        .inc_freq   (inc_freq),
        .noise_in   (noise_in),
        .duty_cycle (duty_cycle),
        .auto_active(auto_active)
    );

    always #5 clk = ~clk;

    function automatic bit m_sample();
        return (m_cyc % DIV) == DIV - 1;
    endfunction

    function automatic bit m_ready();
        return m_live && !m_pend;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_pending();
        p_wave  = m_wave;
        p_amp   = m_amp;
        p_inc   = m_inc;
        p_noise = m_noise;
        p_duty  = m_duty;
        m_pend  = 1'b1;
    endtask

    // Advance the model across one clock edge with the inputs held at that edge
    task automatic model_edge(input bit r, input bit v, input int op, input int d);
        bit s, x;
        if (r) begin
            m_live = 0; m_auto = 0; m_pend = 0; m_err = 0; last_xfer = 0;
            m_cyc = 0; m_dwell = 0; m_wave = 0; p_wave = 0;
            m_amp = 0; m_inc = 0; m_noise = 0; m_duty = 0;
            p_amp = 0; p_inc = 0; p_noise = 0; p_duty = 0;
            return;
        end
        s = m_sample();
        x = v && m_ready();
        m_err = 0;
        if (m_auto && s) begin
            m_dwell++;
            if (m_dwell == DWELL) begin
                m_dwell = 0;
                m_wave  = (m_wave + 1) % 5;
            end
        end
        if (m_pend && s) begin
            m_amp   = p_amp;
            m_inc   = p_inc;
            m_noise = p_noise;
            m_duty  = p_duty;
            if (!m_auto) m_wave = p_wave;
            m_pend = 0;
        end
        if (x) begin
            case (op)
                0: if (m_auto || d > 4) m_err = 1;
                   else begin load_pending(); p_wave = d; end
                1: begin load_pending(); p_noise = d[2]; p_amp = d[1]; p_duty = d[0]; end
                2: begin load_pending(); p_inc = d[0]; end
                3: if (m_auto) m_err = 1;
                   else begin m_auto = 1; m_dwell = 0; end
                4: if (!m_auto) m_err = 1;
                   else m_auto = 0;
                default: m_err = 1;
            endcase
        end
        m_cyc++;
        m_live = 1;
        last_xfer = x;
    endtask

    task automatic compare_all();
        check("sample",      sample,      m_sample());
        check("cmd_ready",   cmd_ready,   m_ready());
        check("cmd_err",     cmd_err,     m_err);
        check("wave_sel",    wave_sel,    m_wave);
        check("amp",         amp,         m_amp);
        check("inc_freq",    inc_freq,    m_inc);
        check("noise_in",    noise_in,    m_noise);
        check("duty_cycle",  duty_cycle,  m_duty);
        check("auto_active", auto_active, m_auto);
    endtask

    task automatic cyc(input bit r, input bit v, input int op, input int d);
        rst_n     = r;
        cmd_valid = v;
        cmd_op    = op[2:0];
        cmd_data  = d[2:0];
        @(posedge clk);
        model_edge(r, v, op, d);
        #1;
        compare_all();
        if (last_xfer)
            $display("[TB] t=%0t xfer op=%0d data=%0d err=%0d wave=%0d auto=%0d",
                     $time, op, d, m_err, m_wave, m_auto);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic send(input int op, input int d);
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, op, d);
            if (last_xfer) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic wait_sample();
        for (int k = 0; k < 2 * DIV; k++) begin
            if (m_sample()) return;
            cyc(0, 0, 0, 0);
        end
        check("sample_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);

        // Cycle 0 after release, then SET_WAVE 3 in cycle 1
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 3);
        idle(6);

        // SET_FLAGS accepted in a strobe cycle commits one strobe later
        wait_sample();
        cyc(0, 1, 1, 3'b110);
        idle(10);

        // Auto sweep from wave 3, then stop
        send(3, 0);
        idle(24);
        send(4, 0);
        idle(12);

        // Error cases in idle
        send(6, 0);
        idle(2);
        send(0, 5);
        idle(2);
        send(4, 0);
        idle(2);

        // Errors and flag commits while sweeping
        send(3, 0);
        send(0, 2);
        send(3, 0);
        send(1, 3'b001);
        send(2, 1);
        idle(12);
        send(4, 0);
        idle(4);

        // Reset while a command is pending discards it
        send(2, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            int op, d;
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 2) == 0);
            op = $urandom_range(0, 7);
            d  = $urandom_range(0, 7);
            cyc(r, v, op, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
